// File: rtl/alu_core.sv
// Purpose: 8-bit sequential ALU; one launch at a time, result registered, alu_done pulses once per op.
// Latency: start sampled at edge N -> result/alu_done valid after edge N+2 (simple) or N+9 (mul/div/mod).
// Backpressure: none; alu_start is a level request honoured only in IDLE, ignored while busy.
//
// Ports:
//   clk        rising-edge clock (gated upstream, consumed only)
//   reset      asynchronous active-high reset
//   alu_start  launch request, sampled in IDLE
//   a, b, op   operands/opcode, copied into internal latches at launch
//   result     registered result, changes only on completion
//   alu_done   one-cycle completion pulse, aligned with the new result
module alu_core #(
  parameter int WIDTH    = 8,
  parameter int OP_W     = 6,
  parameter int ITER_CYC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             alu_done
);

  localparam int CNT_W = $clog2(ITER_CYC);
  localparam int SH_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CYC - 1);

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SHR = OP_W'(7);
  localparam logic [OP_W-1:0] OP_INC = OP_W'(8);
  localparam logic [OP_W-1:0] OP_DEC = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(10);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MOD = OP_W'(12);
  localparam logic [OP_W-1:0] OP_EQ  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LTU = OP_W'(14);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // MUL partial product
  logic [WIDTH-1:0] quo_q, quo_d;   // MUL: shifting multiplier; DIV: dividend/quotient shift reg
  logic [WIDTH-1:0] rem_q, rem_d;   // DIV/MOD partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   divisor;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_fin;

  function automatic logic is_iter(input logic [OP_W-1:0] o);
    return (o == OP_MUL) || (o == OP_DIV) || (o == OP_MOD);
  endfunction

  // Restoring divide step: bring the next dividend bit into the remainder,
  // subtract the divisor when it fits and record a quotient 1.
  always_comb begin
    trial   = {rem_q, quo_q[WIDTH-1]};
    divisor = {1'b0, b_q};
    diff    = trial - divisor;
  end

  // Final value written to result on the DONE transition.
  always_comb begin
    res_fin = '0;
    case (op_q)
      OP_ADD:  res_fin = a_q + b_q;
      OP_SUB:  res_fin = a_q - b_q;
      OP_AND:  res_fin = a_q & b_q;
      OP_OR:   res_fin = a_q | b_q;
      OP_XOR:  res_fin = a_q ^ b_q;
      OP_NOT:  res_fin = ~a_q;
      OP_SHL:  res_fin = a_q << b_q[SH_W-1:0];
      OP_SHR:  res_fin = a_q >> b_q[SH_W-1:0];
      OP_INC:  res_fin = a_q + WIDTH'(1);
      OP_DEC:  res_fin = a_q - WIDTH'(1);
      OP_MUL:  res_fin = acc_q;
      OP_DIV:  res_fin = (b_q == '0) ? '1 : quo_q;
      OP_MOD:  res_fin = (b_q == '0) ? '1 : rem_q;
      OP_EQ:   res_fin = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      OP_LTU:  res_fin = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      default: res_fin = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (alu_start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          acc_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          quo_d   = (op == OP_MUL) ? b : a;
          state_d = is_iter(op) ? ST_ITER : ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_ITER: begin
        if (op_q == OP_MUL) begin
          // Shift-add: multiplier bit cnt selects a<<cnt; only low WIDTH bits kept.
          if (quo_q[0]) acc_d = acc_q + (a_q << cnt_q);
          quo_d = quo_q >> 1;
        end else if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        result_d = res_fin;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result   = result_q;
  assign alu_done = done_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_start;
  logic [7:0] a, b;
  logic [5:0] op;
  logic [7:0] result;
  logic       alu_done;

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  alu_core dut (
    .clk      (clk),
    .reset    (reset),
    .alu_start(alu_start),
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (result),
    .alu_done (alu_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] ref_alu(input logic [5:0] o, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    case (o)
      6'd0:  return x + y;
      6'd1:  return x - y;
      6'd2:  return x & y;
      6'd3:  return x | y;
      6'd4:  return x ^ y;
      6'd5:  return ~x;
      6'd6:  return x << y[2:0];
      6'd7:  return x >> y[2:0];
      6'd8:  return x + 8'd1;
      6'd9:  return x - 8'd1;
      6'd10: begin p = x * y; return p[7:0]; end
      6'd11: return (y == 0) ? 8'hFF : x / y;
      6'd12: return (y == 0) ? 8'hFF : x % y;
      6'd13: return (x == y) ? 8'd1 : 8'd0;
      6'd14: return (x < y) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  // Scoreboard: every completion pulse must match the oldest expectation
  // in value and in the cycle it appears.
  always @(negedge clk) begin
    if (alu_done === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("result", {24'd0, result}, {24'd0, mon_e.res});
        check_val("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_val("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [5:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    op = o; a = x; b = y; alu_start = 1'b1;
    @(posedge clk);
    #1;
    e.res = ref_alu(o, x, y);
    e.cyc = cyc + (((o >= 6'd10) && (o <= 6'd12)) ? 9 : 2);
    sb.push_back(e);
    alu_start = 1'b0;
    // Scramble the inputs so the DUT must use its launch-time copies.
    a = ~x; b = y ^ 8'h5A; op = o ^ 6'h15;
    wait_drain();
  endtask

  typedef struct {
    logic [5:0] o;
    logic [7:0] x;
    logic [7:0] y;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{6'd0,  8'd200, 8'd100},
      '{6'd1,  8'd5,   8'd7},
      '{6'd5,  8'h0F,  8'h33},
      '{6'd6,  8'd1,   8'd3},
      '{6'd7,  8'h80,  8'd7},
      '{6'd2,  8'hF0,  8'h3C},
      '{6'd3,  8'hF0,  8'h0C},
      '{6'd0,  8'd255, 8'd1},
      '{6'd8,  8'd255, 8'd9},
      '{6'd9,  8'd0,   8'd9},
      '{6'd10, 8'd13,  8'd11},
      '{6'd10, 8'd255, 8'd255},
      '{6'd11, 8'd100, 8'd7},
      '{6'd12, 8'd100, 8'd7},
      '{6'd11, 8'd9,   8'd0},
      '{6'd12, 8'd9,   8'd0},
      '{6'd13, 8'd42,  8'd42},
      '{6'd13, 8'd42,  8'd43},
      '{6'd14, 8'd3,   8'd200},
      '{6'd14, 8'd200, 8'd3},
      '{6'd40, 8'd12,  8'd34},
      '{6'd63, 8'hFF,  8'hFF}
    };

    reset = 1'b1; alu_start = 1'b0; a = 8'd0; b = 8'd0; op = 6'd0;
    #1;
    check_val("reset_result", {24'd0, result}, 32'd0);
    check_val("reset_done", {31'd0, alu_done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].o, vecs[i].x, vecs[i].y);

    // Leave a nonzero result so the abort clearing it is observable.
    run_op(6'd0, 8'd3, 8'd4);

    // Reset four cycles into a multiply: no completion, result cleared.
    op = 6'd10; a = 8'd13; b = 8'd11; alu_start = 1'b1;
    @(posedge clk);
    #1 alu_start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("abort_result", {24'd0, result}, 32'd0);
    check_val("abort_done", {31'd0, alu_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check_val("abort_hold", {24'd0, result}, 32'd0);
    // Back in IDLE: a fresh simple op must complete with normal latency.
    run_op(6'd0, 8'd1, 8'd2);

    // Back-to-back with alu_start held high, inputs changed mid-flight.
    begin
      exp_t e1, e2;
      op = 6'd0; a = 8'd10; b = 8'd20; alu_start = 1'b1;
      @(posedge clk);
      #1;
      e1.res = 8'd30;  e1.cyc = cyc + 2;
      e2.res = 8'h55;  e2.cyc = cyc + 5;
      sb.push_back(e1);
      sb.push_back(e2);
      op = 6'd4; a = 8'hAA; b = 8'hFF;
      repeat (3) @(posedge clk);
      #1 alu_start = 1'b0;
      wait_drain();
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
